// File: rtl/count_drain_pkg.sv
// count_drain_pkg: shared types and constants for the count_drain slice.
//   state_t  - drain FSM states
//   STATE_W  - encoded state width
//   STATS_W  - width of the optional statistics counters
//   imax     - constant-foldable max, used to size the shared timer
package count_drain_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int STATE_W = 2;
  localparam int STATS_W = 16;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/count_drain_if.sv
// count_drain_if: counter-side and consumer-side signals of count_drain.
//   non_zero/val   : counter status (into drain)
//   clr            : clear pulse back to the counter
//   ev_valid/ready : replayed-event handshake
//   pending/busy   : drain status
//   ev_total/cap_total : statistics, present only with COUNT_DRAIN_STATS_EN
// Modports: master = the drain block, slave = its environment.
interface count_drain_if #(parameter int WIDTH_P = 4);
  logic               non_zero;
  logic [WIDTH_P-1:0] val;
  logic               clr;
  logic               ev_valid;
  logic               ev_ready;
  logic [WIDTH_P-1:0] pending;
  logic               busy;
`ifdef COUNT_DRAIN_STATS_EN
  logic [count_drain_pkg::STATS_W-1:0] ev_total;
  logic [count_drain_pkg::STATS_W-1:0] cap_total;

  modport master (input non_zero, val, ev_ready,
                  output clr, ev_valid, pending, busy, ev_total, cap_total);
  modport slave  (output non_zero, val, ev_ready,
                  input clr, ev_valid, pending, busy, ev_total, cap_total);
`else
  modport master (input non_zero, val, ev_ready,
                  output clr, ev_valid, pending, busy);
  modport slave  (output non_zero, val, ev_ready,
                  input clr, ev_valid, pending, busy);
`endif
endinterface

// File: rtl/count_drain_timer.sv
// count_drain_timer: loadable down-counter that stops at zero.
//   clk2, reset_L : clock, async active-low reset
//   i_load        : load i_load_val this cycle (wins over counting)
//   i_load_val    : value to load
//   o_cnt         : current count
//   o_done        : count is zero
module count_drain_timer #(
  parameter int W = 2
) (
  input  logic         clk2,
  input  logic         reset_L,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk2 or negedge reset_L) begin
    if (!reset_L)              r_cnt <= '0;
    else if (i_load)           r_cnt <= i_load_val;
    else if (r_cnt != '0)      r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/count_drain.sv
// count_drain: clk2-domain consumer of the clk1->clk2 event counter.
// Snapshots the counter value, clears the counter, then replays the count
// as one ev_valid/ev_ready handshake per event with an optional idle gap.
//   clk2, reset_L : clock, async active-low reset
//   bus (master)  : non_zero/val in, clr out, ev_valid out/ev_ready in,
//                   pending/busy out
// Optional macro COUNT_DRAIN_STATS_EN adds saturating ev_total/cap_total.
module count_drain
  import count_drain_pkg::*;
#(
  parameter int WIDTH_P = 4,
  parameter int HOLD_P  = 3,
  parameter int GAP_P   = 0
) (
  input  logic          clk2,
  input  logic          reset_L,
  count_drain_if.master bus
);
  // Timer is loaded with N-1 so that the owning state lasts exactly N cycles.
  localparam int T_W = $clog2(imax(HOLD_P, GAP_P) + 1);
  localparam logic [T_W-1:0] HOLD_LD = T_W'(HOLD_P - 1);
  localparam logic [T_W-1:0] GAP_LD  = (GAP_P > 0) ? T_W'(GAP_P - 1) : '0;

  state_t             r_state, w_state_n;
  logic [WIDTH_P-1:0] r_pending, w_pend_n, w_pend_dec;
  logic               r_clr, r_ev_valid, r_busy;
  logic               w_clr_n, w_hs, w_ld, w_tdone;
  logic [T_W-1:0]     w_ld_val, w_tcnt, w_hold_rem, w_gap_from_hold;

  assign w_hs       = r_ev_valid & bus.ev_ready;
  assign w_pend_dec = r_pending - WIDTH_P'(1);
  // HOLD cycles still owed after this edge; a gap entered from HOLD must
  // cover them so IDLE is never reached before the hold window closes.
  assign w_hold_rem      = w_tdone ? '0 : (w_tcnt - T_W'(1));
  assign w_gap_from_hold = (w_hold_rem > GAP_LD) ? w_hold_rem : GAP_LD;

  count_drain_timer #(.W(T_W)) u_timer (
    .clk2       (clk2),
    .reset_L    (reset_L),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .o_cnt      (w_tcnt),
    .o_done     (w_tdone)
  );

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pending;
    w_clr_n   = 1'b0;
    w_ld      = 1'b0;
    w_ld_val  = '0;
    case (r_state)
      IDLE: begin
        // non_zero with val==0 is sync skew between the two counter outputs
        if (bus.non_zero && (bus.val != '0)) begin
          w_pend_n  = bus.val;
          w_clr_n   = 1'b1;
          w_state_n = HOLD;
          w_ld      = 1'b1;
          w_ld_val  = HOLD_LD;
        end
      end
      HOLD: begin
        // events may already be accepted while the counter clear settles
        if (w_hs) begin
          w_pend_n = w_pend_dec;
          if (r_pending == WIDTH_P'(1)) begin
            w_state_n = w_tdone ? IDLE : HOLD;
          end else if (GAP_P > 0) begin
            w_state_n = GAP;
            w_ld      = 1'b1;
            w_ld_val  = w_gap_from_hold;
          end else if (w_tdone) begin
            w_state_n = DRAIN;
          end
        end else if (w_tdone) begin
          w_state_n = (r_pending == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (w_hs) begin
          w_pend_n = w_pend_dec;
          if (r_pending == WIDTH_P'(1)) begin
            w_state_n = IDLE;
          end else if (GAP_P > 0) begin
            w_state_n = GAP;
            w_ld      = 1'b1;
            w_ld_val  = GAP_LD;
          end
        end
      end
      GAP: begin
        if (w_tdone) w_state_n = DRAIN;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_clr      <= 1'b0;
      r_ev_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pending  <= w_pend_n;
      r_clr      <= w_clr_n;
      r_ev_valid <= ((w_state_n == HOLD) || (w_state_n == DRAIN)) && (w_pend_n != '0);
      r_busy     <= (w_state_n != IDLE);
    end
  end

  assign bus.clr      = r_clr;
  assign bus.ev_valid = r_ev_valid;
  assign bus.pending  = r_pending;
  assign bus.busy     = r_busy;

`ifdef COUNT_DRAIN_STATS_EN
  logic [STATS_W-1:0] r_ev_total, r_cap_total;

  always_ff @(posedge clk2 or negedge reset_L) begin
    if (!reset_L) begin
      r_ev_total  <= '0;
      r_cap_total <= '0;
    end else begin
      if (w_hs && !(&r_ev_total))     r_ev_total  <= r_ev_total + STATS_W'(1);
      if (w_clr_n && !(&r_cap_total)) r_cap_total <= r_cap_total + STATS_W'(1);
    end
  end

  assign bus.ev_total  = r_ev_total;
  assign bus.cap_total = r_cap_total;
`endif
endmodule
